control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  SAP2 fetch/decode/execute sequencer; issues the control words that drive PC, MAR, RAM, IR, A, T, ALU and OUT.
//  It supplies i_op and i_latch_flags to the ALU and consumes its registered zero/carry/odd flags.
//  Those flags resolve the conditional jumps JZ, JC and JO.
//  Holds T-state counter and halt state; all control outputs decode combinationally from state + i_instr.
// PARAMETERS
//  WIDTH         8  data/instruction width; opcode = i_instr[WIDTH-1:WIDTH-4], operand = i_instr[3:0]
//  NUM_TSTATES   6  T-states per instruction when early end is disabled (T0..T5)
// PORTS
//  clk            in   1             system clock, rising edge
//  rst_n          in   1             asynchronous, active-low reset
//  clk_en         in   1             state advances only on clk edges with clk_en=1
//  i_instr        in   WIDTH         current IR contents
//  i_zero         in   1             ALU latched zero flag
//  i_carry        in   1             ALU latched carry flag
//  i_odd          in   1             ALU latched odd flag
//  o_pc_out/o_pc_inc/o_pc_load      out 1  program counter controls
//  o_mar_load, o_ram_out, o_ram_load out 1  memory controls
//  o_ir_load, o_ir_out               out 1  IR load / drive operand nibble (zero-extended) on bus
//  o_a_load, o_a_out, o_t_load       out 1  register controls
//  o_alu_out      out  1             ALU result onto bus
//  o_alu_op       out  ALU_OP_WIDTH  ALU operation select
//  o_latch_flags  out  1             ALU flag latch enable
//  o_out_load     out  1             output register load
//  o_halted       out  1             sticky halt indicator
//  o_tstate       out  3             current T-state, for debug/display
// BEHAVIOUR
//  Reset (async, any time, mid-instruction included):
//   - T-state=0, halted=0, so every control output=0 except T0 decode (o_pc_out=o_mar_load=1).
//   - o_alu_op=ALU_ADD whenever no ALU step is active.
//  Fetch, identical for all opcodes:
//   - T0: pc_out, mar_load.
//   - T1: ram_out, ir_load, pc_inc.
//  Execute, by opcode:
//   - NOP 0: no controls.
//   - LDA 1: T2 ir_out+mar_load; T3 ram_out+a_load.
//   - ADD 2 / SUB 3: T2 ir_out+mar_load; T3 ram_out+t_load; T4 alu_out+a_load+latch_flags, alu_op=ADD/SUB.
//   - STA 4: T2 ir_out+mar_load; T3 a_out+ram_load.
//   - LDI 5: T2 ir_out+a_load.
//   - JMP 6: T2 ir_out+pc_load.
//   - JZ 7 / JC 8 / JO 9: T2 ir_out always; pc_load only if i_zero / i_carry / i_odd is 1, sampled in T2.
//   - ALU A: T2 alu_out+a_load+latch_flags, alu_op=i_instr[ALU_OP_WIDTH-1:0].
//   - OUT E: T2 a_out+out_load.
//   - HLT F: in T2, halted<=1 on the next enabled edge.
//   - B,C,D: decode as NOP.
//  Halted: T-state frozen; all controls 0; o_halted=1 until rst_n; clk_en ignored.
//  clk_en=0: state holds and outputs stay stable; consumers qualify their loads with clk_en.
//  Flag timing: flags latched at the end of ALU step Tn are visible to any later instruction's T2.
//  Bus exclusivity: at most one of pc_out/ram_out/ir_out/a_out/alu_out is 1 in any state (assertion).
// CONFIGURATION
//  SEQ_EARLY_END_EN defined:
//   - the last execute step of each instruction returns to T0 on the next enabled edge.
//   - ADD/SUB=5 cycles, LDA/STA=4, others=3; NOP ends after T2.
//  Undefined:
//   - counter runs T0..NUM_TSTATES-1 then wraps to T0; every instruction takes 6 cycles.
//   - unused steps issue no controls.
// STRUCTURE
//  Shared control_words.vi holds opcode localparams (OP_NOP..OP_HLT), ALU_OP_WIDTH and ALU_* codes.
//  Sub-module tstate_counter: async-reset counter with clk_en, hold and early-clear inputs.
//  Instruction decode stays in this module as one combinational case on {opcode, tstate}.
// TESTING
//  - Reset, clk_en=1, i_instr=8'h00: o_tstate 0,1,2,0 (early end) or 0..5,0 (disabled); T0 has pc_out+mar_load only.
//  - i_instr=8'h2C: T4 gives alu_op=ALU_ADD, alu_out=a_load=latch_flags=1; cycle count 5 (early) / 6.
//  - i_instr=8'h73: i_zero=0 -> no pc_load in T2; i_zero=1 -> pc_load=ir_out=1 in T2. Repeat for JC with i_carry, JO with i_odd.
//  - i_instr=8'hA0|ALU_ROL: T2 alu_op=ALU_ROL, latch_flags=1; clk_en=0 for 3 cycles mid-T2 -> outputs stable, o_tstate stays 2.
//  - i_instr=8'hF0: o_halted=1 after T2 edge; 10 further clocks leave state frozen and controls 0; rst_n low clears it.
//  - rst_n asserted asynchronously during ADD T3: o_tstate=0 and t_load=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// control_sequencer_pkg
// Shared definitions for the SAP2 control sequencer:
//   - opcode values (OP_NOP .. OP_HLT)
//   - ALU operation width and ALU_* operation codes
//   - ctrl_word_t, the bundle of control lines issued in one T-state
//   - idle_word(): the "nothing active" control word (alu_op parked on ADD)
//   - last_step(): final execute T-state of each opcode, used when the
//     early-end build option (SEQ_EARLY_END_EN) is enabled
// -----------------------------------------------------------------------------
package control_sequencer_pkg;

    localparam int TSTATE_W     = 3;
    localparam int ALU_OP_WIDTH = 4;

    // Opcodes (upper nibble of the instruction)
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_JC  = 4'h8;
    localparam logic [3:0] OP_JO  = 4'h9;
    localparam logic [3:0] OP_ALU = 4'hA;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // ALU operation codes
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR = 4'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_NOT = 4'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ROL = 4'd6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ROR = 4'd7;

    typedef struct packed {
        logic                    pc_out;
        logic                    pc_inc;
        logic                    pc_load;
        logic                    mar_load;
        logic                    ram_out;
        logic                    ram_load;
        logic                    ir_load;
        logic                    ir_out;
        logic                    a_load;
        logic                    a_out;
        logic                    t_load;
        logic                    alu_out;
        logic                    latch_flags;
        logic                    out_load;
        logic [ALU_OP_WIDTH-1:0] alu_op;
    } ctrl_word_t;

    function automatic ctrl_word_t idle_word();
        ctrl_word_t w;
        w        = '0;
        w.alu_op = ALU_ADD;
        return w;
    endfunction

    // Final T-state of each instruction when execution ends early.
    function automatic logic [TSTATE_W-1:0] last_step(input logic [3:0] op);
        logic [TSTATE_W-1:0] s;
        case (op)
            OP_ADD, OP_SUB: s = 3'd4;
            OP_LDA, OP_STA: s = 3'd3;
            default:        s = 3'd2;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/control_sequencer_chk.sv
// -----------------------------------------------------------------------------
// control_sequencer_chk
// Property checker for control_sequencer (no logic, assertions only).
//   clk, rst_n                       : clock / reset of the checked block
//   pc_out, ram_out, ir_out, a_out,
//   alu_out                          : bus drivers (at most one may be active)
//   halted                           : sticky halt; no bus driver while halted
// -----------------------------------------------------------------------------
module control_sequencer_chk (
    input logic clk,
    input logic rst_n,
    input logic pc_out,
    input logic ram_out,
    input logic ir_out,
    input logic a_out,
    input logic alu_out,
    input logic halted
);

    logic [4:0] bus_drv_s;
    assign bus_drv_s = {pc_out, ram_out, ir_out, a_out, alu_out};

    a_bus_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus_drv_s));

    a_halt_quiet: assert property (@(posedge clk) disable iff (!rst_n)
        halted |-> (bus_drv_s == 5'd0));

endmodule

// File: rtl/control_sequencer_tstate_counter.sv
// -----------------------------------------------------------------------------
// tstate_counter
// T-state counter for the sequencer. Counts 0..NUM_TSTATES-1 and wraps.
//   clk, rst_n  : clock, asynchronous active-low reset (count -> 0)
//   clk_en      : count changes only on enabled edges
//   hold        : freeze the count (takes precedence over clear/advance)
//   clear       : return to T0 on the next enabled edge (early end)
//   o_tstate    : current T-state
// -----------------------------------------------------------------------------
module tstate_counter
    import control_sequencer_pkg::*;
#(
    parameter int NUM_TSTATES = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_en,
    input  logic                hold,
    input  logic                clear,
    output logic [TSTATE_W-1:0] o_tstate
);

    localparam logic [TSTATE_W-1:0] LAST_T = TSTATE_W'(NUM_TSTATES - 1);

    logic [TSTATE_W-1:0] tstate_q;
    logic [TSTATE_W-1:0] tstate_d;

    // Next-count selection: hold, clear/wrap, or advance.
    always_comb begin
        tstate_d = tstate_q;
        if (!clk_en || hold) begin
            tstate_d = tstate_q;
        end else if (clear || (tstate_q == LAST_T)) begin
            tstate_d = 3'd0;
        end else begin
            tstate_d = tstate_q + 3'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tstate_q <= 3'd0;
        end else begin
            tstate_q <= tstate_d;
        end
    end

    assign o_tstate = tstate_q;

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// SAP2 fetch/decode/execute sequencer. Holds the T-state counter and the halt
// flag; every control output is decoded combinationally from the current
// T-state, halt state, i_instr and the ALU's latched flags.
// Build option: SEQ_EARLY_END_EN -- when defined, each instruction returns to
// T0 right after its last execute step instead of running all NUM_TSTATES.
// Ports:
//   clk, rst_n, clk_en              : clock, async active-low reset, advance enable
//   i_instr                         : IR contents (opcode = top nibble)
//   i_zero, i_carry, i_odd          : ALU latched flags for JZ / JC / JO
//   o_pc_out/o_pc_inc/o_pc_load     : program counter controls
//   o_mar_load/o_ram_out/o_ram_load : memory controls
//   o_ir_load/o_ir_out              : IR load / operand onto bus
//   o_a_load/o_a_out/o_t_load       : register controls
//   o_alu_out/o_alu_op/o_latch_flags: ALU controls
//   o_out_load                      : output register load
//   o_halted                        : sticky halt
//   o_tstate                        : current T-state (debug)
// -----------------------------------------------------------------------------
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int NUM_TSTATES = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk_en,
    input  logic [WIDTH-1:0]        i_instr,
    input  logic                    i_zero,
    input  logic                    i_carry,
    input  logic                    i_odd,
    output logic                    o_pc_out,
    output logic                    o_pc_inc,
    output logic                    o_pc_load,
    output logic                    o_mar_load,
    output logic                    o_ram_out,
    output logic                    o_ram_load,
    output logic                    o_ir_load,
    output logic                    o_ir_out,
    output logic                    o_a_load,
    output logic                    o_a_out,
    output logic                    o_t_load,
    output logic                    o_alu_out,
    output logic [ALU_OP_WIDTH-1:0] o_alu_op,
    output logic                    o_latch_flags,
    output logic                    o_out_load,
    output logic                    o_halted,
    output logic [2:0]              o_tstate
);

    logic [3:0]          opcode_s;
    logic [TSTATE_W-1:0] tstate_s;
    logic                halt_now_s;
    logic                clear_s;
    logic                halted_q;
    logic                halted_d;
    ctrl_word_t          ctrl_s;

    assign opcode_s = i_instr[WIDTH-1 -: 4];

    // HLT in T2 sets the halt flag; the counter is frozen from that edge on.
    assign halt_now_s = !halted_q && (opcode_s == OP_HLT) && (tstate_s == 3'd2);

`ifdef SEQ_EARLY_END_EN
    assign clear_s = (tstate_s == last_step(opcode_s));
`else
    assign clear_s = 1'b0;
`endif

    tstate_counter #(
        .NUM_TSTATES (NUM_TSTATES)
    ) u_tstate_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_en   (clk_en),
        .hold     (halted_q || halt_now_s),
        .clear    (clear_s),
        .o_tstate (tstate_s)
    );

    // Halt next-state: sticky once set, only reset clears it.
    always_comb begin
        halted_d = halted_q;
        if (halted_q) begin
            halted_d = 1'b1;
        end else if (clk_en && halt_now_s) begin
            halted_d = 1'b1;
        end else begin
            halted_d = 1'b0;
        end
    end

    // Halt register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    // Control decode: shared fetch in T0/T1, then execute by {opcode, tstate}.
    always_comb begin
        ctrl_s = idle_word();
        if (halted_q) begin
            ctrl_s = idle_word();
        end else if (tstate_s == 3'd0) begin
            ctrl_s.pc_out   = 1'b1;
            ctrl_s.mar_load = 1'b1;
        end else if (tstate_s == 3'd1) begin
            ctrl_s.ram_out = 1'b1;
            ctrl_s.ir_load = 1'b1;
            ctrl_s.pc_inc  = 1'b1;
        end else begin
            case ({opcode_s, tstate_s})
                {OP_LDA, 3'd2}, {OP_ADD, 3'd2}, {OP_SUB, 3'd2}, {OP_STA, 3'd2}: begin
                    ctrl_s.ir_out   = 1'b1;
                    ctrl_s.mar_load = 1'b1;
                end
                {OP_LDA, 3'd3}: begin
                    ctrl_s.ram_out = 1'b1;
                    ctrl_s.a_load  = 1'b1;
                end
                {OP_ADD, 3'd3}, {OP_SUB, 3'd3}: begin
                    ctrl_s.ram_out = 1'b1;
                    ctrl_s.t_load  = 1'b1;
                end
                {OP_ADD, 3'd4}: begin
                    ctrl_s.alu_out     = 1'b1;
                    ctrl_s.a_load      = 1'b1;
                    ctrl_s.latch_flags = 1'b1;
                    ctrl_s.alu_op      = ALU_ADD;
                end
                {OP_SUB, 3'd4}: begin
                    ctrl_s.alu_out     = 1'b1;
                    ctrl_s.a_load      = 1'b1;
                    ctrl_s.latch_flags = 1'b1;
                    ctrl_s.alu_op      = ALU_SUB;
                end
                {OP_STA, 3'd3}: begin
                    ctrl_s.a_out    = 1'b1;
                    ctrl_s.ram_load = 1'b1;
                end
                {OP_LDI, 3'd2}: begin
                    ctrl_s.ir_out = 1'b1;
                    ctrl_s.a_load = 1'b1;
                end
                {OP_JMP, 3'd2}: begin
                    ctrl_s.ir_out  = 1'b1;
                    ctrl_s.pc_load = 1'b1;
                end
                {OP_JZ, 3'd2}: begin
                    ctrl_s.ir_out  = 1'b1;
                    ctrl_s.pc_load = i_zero;
                end
                {OP_JC, 3'd2}: begin
                    ctrl_s.ir_out  = 1'b1;
                    ctrl_s.pc_load = i_carry;
                end
                {OP_JO, 3'd2}: begin
                    ctrl_s.ir_out  = 1'b1;
                    ctrl_s.pc_load = i_odd;
                end
                {OP_ALU, 3'd2}: begin
                    ctrl_s.alu_out     = 1'b1;
                    ctrl_s.a_load      = 1'b1;
                    ctrl_s.latch_flags = 1'b1;
                    ctrl_s.alu_op      = i_instr[ALU_OP_WIDTH-1:0];
                end
                {OP_OUT, 3'd2}: begin
                    ctrl_s.a_out    = 1'b1;
                    ctrl_s.out_load = 1'b1;
                end
                default: begin
                    ctrl_s = idle_word();
                end
            endcase
        end
    end

    assign o_pc_out      = ctrl_s.pc_out;
    assign o_pc_inc      = ctrl_s.pc_inc;
    assign o_pc_load     = ctrl_s.pc_load;
    assign o_mar_load    = ctrl_s.mar_load;
    assign o_ram_out     = ctrl_s.ram_out;
    assign o_ram_load    = ctrl_s.ram_load;
    assign o_ir_load     = ctrl_s.ir_load;
    assign o_ir_out      = ctrl_s.ir_out;
    assign o_a_load      = ctrl_s.a_load;
    assign o_a_out       = ctrl_s.a_out;
    assign o_t_load      = ctrl_s.t_load;
    assign o_alu_out     = ctrl_s.alu_out;
    assign o_alu_op      = ctrl_s.alu_op;
    assign o_latch_flags = ctrl_s.latch_flags;
    assign o_out_load    = ctrl_s.out_load;
    assign o_halted      = halted_q;
    assign o_tstate      = tstate_s;

    control_sequencer_chk u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .pc_out  (ctrl_s.pc_out),
        .ram_out (ctrl_s.ram_out),
        .ir_out  (ctrl_s.ir_out),
        .a_out   (ctrl_s.a_out),
        .alu_out (ctrl_s.alu_out),
        .halted  (halted_q)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
// Self-checking bench: a per-instruction microprogram table plus a T-state /
// halt model predict every control output each cycle.
// -----------------------------------------------------------------------------
module tb_control_sequencer;
    import control_sequencer_pkg::*;

    // Control-line masks, bit order matches the packing of act_word().
    localparam logic [13:0] M_PC_OUT   = 14'h2000;
    localparam logic [13:0] M_PC_INC   = 14'h1000;
    localparam logic [13:0] M_PC_LOAD  = 14'h0800;
    localparam logic [13:0] M_MAR_LOAD = 14'h0400;
    localparam logic [13:0] M_RAM_OUT  = 14'h0200;
    localparam logic [13:0] M_RAM_LOAD = 14'h0100;
    localparam logic [13:0] M_IR_LOAD  = 14'h0080;
    localparam logic [13:0] M_IR_OUT   = 14'h0040;
    localparam logic [13:0] M_A_LOAD   = 14'h0020;
    localparam logic [13:0] M_A_OUT    = 14'h0010;
    localparam logic [13:0] M_T_LOAD   = 14'h0008;
    localparam logic [13:0] M_ALU_OUT  = 14'h0004;
    localparam logic [13:0] M_LATCH    = 14'h0002;
    localparam logic [13:0] M_OUT_LOAD = 14'h0001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_en;
    logic [7:0] i_instr;
    logic       i_zero, i_carry, i_odd;
    logic       o_pc_out, o_pc_inc, o_pc_load, o_mar_load, o_ram_out, o_ram_load;
    logic       o_ir_load, o_ir_out, o_a_load, o_a_out, o_t_load, o_alu_out;
    logic [3:0] o_alu_op;
    logic       o_latch_flags, o_out_load, o_halted;
    logic [2:0] o_tstate;

    int checks = 0;
    int errors = 0;
    int m_t = 0;
    bit m_halted = 1'b0;

    always #5 clk = ~clk;

    control_sequencer #(.WIDTH(8), .NUM_TSTATES(6)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_instr(i_instr),
        .i_zero(i_zero), .i_carry(i_carry), .i_odd(i_odd),
        .o_pc_out(o_pc_out), .o_pc_inc(o_pc_inc), .o_pc_load(o_pc_load),
        .o_mar_load(o_mar_load), .o_ram_out(o_ram_out), .o_ram_load(o_ram_load),
        .o_ir_load(o_ir_load), .o_ir_out(o_ir_out), .o_a_load(o_a_load),
        .o_a_out(o_a_out), .o_t_load(o_t_load), .o_alu_out(o_alu_out),
        .o_alu_op(o_alu_op), .o_latch_flags(o_latch_flags), .o_out_load(o_out_load),
        .o_halted(o_halted), .o_tstate(o_tstate)
    );

    // Cycles an instruction occupies.
    function automatic int cyc_len(input logic [3:0] op);
`ifdef SEQ_EARLY_END_EN
        if (op == 4'h2 || op == 4'h3) return 5;
        if (op == 4'h1 || op == 4'h4) return 4;
        return 3;
`else
        return 6;
`endif
    endfunction

    // Microprogram of one instruction: six slots of {alu_op, control mask}.
    function automatic logic [17:0] model_word(input logic [7:0] instr, input int t,
                                               input bit z, input bit c, input bit o);
        logic [17:0] prog [6];
        logic [3:0]  op;
        op = instr[7:4];
        for (int i = 0; i < 6; i++) prog[i] = {ALU_ADD, 14'h0000};
        prog[0] = {ALU_ADD, M_PC_OUT | M_MAR_LOAD};
        prog[1] = {ALU_ADD, M_RAM_OUT | M_IR_LOAD | M_PC_INC};
        case (op)
            4'h1: begin
                prog[2] = {ALU_ADD, M_IR_OUT | M_MAR_LOAD};
                prog[3] = {ALU_ADD, M_RAM_OUT | M_A_LOAD};
            end
            4'h2, 4'h3: begin
                prog[2] = {ALU_ADD, M_IR_OUT | M_MAR_LOAD};
                prog[3] = {ALU_ADD, M_RAM_OUT | M_T_LOAD};
                prog[4] = {(op == 4'h2) ? ALU_ADD : ALU_SUB, M_ALU_OUT | M_A_LOAD | M_LATCH};
            end
            4'h4: begin
                prog[2] = {ALU_ADD, M_IR_OUT | M_MAR_LOAD};
                prog[3] = {ALU_ADD, M_A_OUT | M_RAM_LOAD};
            end
            4'h5: prog[2] = {ALU_ADD, M_IR_OUT | M_A_LOAD};
            4'h6: prog[2] = {ALU_ADD, M_IR_OUT | M_PC_LOAD};
            4'h7: prog[2] = {ALU_ADD, M_IR_OUT | (z ? M_PC_LOAD : 14'h0000)};
            4'h8: prog[2] = {ALU_ADD, M_IR_OUT | (c ? M_PC_LOAD : 14'h0000)};
            4'h9: prog[2] = {ALU_ADD, M_IR_OUT | (o ? M_PC_LOAD : 14'h0000)};
            4'hA: prog[2] = {instr[3:0], M_ALU_OUT | M_A_LOAD | M_LATCH};
            4'hE: prog[2] = {ALU_ADD, M_A_OUT | M_OUT_LOAD};
            default: ;
        endcase
        return prog[t];
    endfunction

    function automatic logic [17:0] act_word();
        return {o_alu_op, o_pc_out, o_pc_inc, o_pc_load, o_mar_load, o_ram_out,
                o_ram_load, o_ir_load, o_ir_out, o_a_load, o_a_out, o_t_load,
                o_alu_out, o_latch_flags, o_out_load};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_now(input string tag);
        logic [17:0] exp;
        exp = m_halted ? {ALU_ADD, 14'h0000} : model_word(i_instr, m_t, i_zero, i_carry, i_odd);
        chk({tag, "_ctrl"},   {14'h0, act_word()}, {14'h0, exp});
        chk({tag, "_tstate"}, {29'h0, o_tstate},   m_t);
        chk({tag, "_halted"}, {31'h0, o_halted},   {31'h0, m_halted});
    endtask

    // Check outputs, clock once, advance the model. Entered/left at posedge+1.
    task automatic cycle(input string tag);
        int nt;
        bit nh;
        #1;
        check_now(tag);
        nt = m_t;
        nh = m_halted;
        if (!m_halted && clk_en) begin
            if (i_instr[7:4] == 4'hF && m_t == 2) begin
                nh = 1'b1;
            end else begin
                nt = m_t + 1;
                if (nt >= cyc_len(i_instr[7:4])) nt = 0;
            end
        end
        @(posedge clk);
        m_t = nt;
        m_halted = nh;
        #1;
    endtask

    // Run one full instruction (clk_en=1), starting from T0.
    task automatic do_instr(input logic [7:0] instr, input string tag);
        int n;
        i_instr = instr;
        clk_en = 1'b1;
        n = 0;
        do begin
            cycle(tag);
            n++;
        end while (m_t != 0 && n < 20);
        chk({tag, "_len"}, n, cyc_len(instr[7:4]));
    endtask

    task automatic run_to_t(input int t, input string tag);
        int n;
        n = 0;
        while (m_t != t && n < 20) begin
            cycle(tag);
            n++;
        end
        chk({tag, "_reach_t"}, m_t, t);
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; i_instr = 8'h00;
        i_zero = 1'b0; i_carry = 1'b0; i_odd = 1'b0;
        // Reset state
        #3;
        check_now("reset");
        @(posedge clk); #1;
        check_now("reset_hold");
        rst_n = 1'b1;

        // NOP sequence and fetch decode
        do_instr(8'h00, "nop");
        do_instr(8'h2C, "add");
        do_instr(8'h3C, "sub");
        do_instr(8'h15, "lda");
        do_instr(8'h46, "sta");
        do_instr(8'h57, "ldi");
        do_instr(8'h68, "jmp");
        do_instr(8'hE0, "out");
        do_instr(8'hB1, "op_b");

        // Conditional jumps with flag 0 then 1
        for (int f = 0; f < 2; f++) begin
            i_zero = f[0]; i_carry = 1'b0; i_odd = 1'b0;
            do_instr(8'h73, "jz");
            i_zero = 1'b0; i_carry = f[0];
            do_instr(8'h83, "jc");
            i_carry = 1'b0; i_odd = f[0];
            do_instr(8'h93, "jo");
            i_odd = 1'b0;
        end

        // ALU ROL with a 3-cycle stall in T2
        i_instr = 8'hA0 | {4'h0, ALU_ROL};
        run_to_t(2, "rol");
        clk_en = 1'b0;
        for (int k = 0; k < 3; k++) cycle("rol_stall");
        clk_en = 1'b1;
        run_to_t(0, "rol_done");

        // Randomized instruction stream (no HLT), random flags and clk_en
        for (int k = 0; k < 400; k++) begin
            if (m_t == 0) i_instr = 8'($urandom_range(0, 239));
            i_zero  = 1'($urandom);
            i_carry = 1'($urandom);
            i_odd   = 1'($urandom);
            clk_en  = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end
        clk_en = 1'b1;
        run_to_t(0, "rand_end");

        // Asynchronous reset during ADD T3
        i_instr = 8'h2C;
        run_to_t(3, "add_pre_rst");
        #1 rst_n = 1'b0;
        #1;
        m_t = 0; m_halted = 1'b0;
        check_now("async_rst");
        chk("async_rst_t_load", {31'h0, o_t_load}, 32'h0);
        #1 rst_n = 1'b1;
        do_instr(8'h2C, "add_after_rst");

        // HLT, then frozen for 10 clocks, then reset clears it
        i_instr = 8'hF0;
        run_to_t(2, "hlt");
        cycle("hlt_t2");
        chk("hlt_set", {31'h0, o_halted}, 32'h1);
        chk("hlt_tstate", {29'h0, o_tstate}, 32'h2);
        for (int k = 0; k < 10; k++) begin
            clk_en = 1'($urandom);
            i_instr = 8'($urandom);
            cycle("halted");
        end
        #1 rst_n = 1'b0;
        #1;
        m_t = 0; m_halted = 1'b0;
        check_now("hlt_rst");
        #1 rst_n = 1'b1;
        clk_en = 1'b1;
        do_instr(8'h00, "post_hlt");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
